alarm_ctrl: RTL

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: four programmable alarm slots, ring/snooze/timeout
// session FSM and sticky per-slot missed flags.
module alarm_ctrl #(
    parameter int SNOOZE_MIN  = 5,
    parameter int TIMEOUT_MIN = 10,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] time_in,
    input  logic        min_tick,
    input  logic [1:0]  slot_sel,
    input  logic [10:0] time_set_in,
    input  logic        set_time,
    input  logic [3:0]  slot_en,
    input  logic        snooze,
    input  logic        end_ring,
    input  logic        clear_missed,
    output logic        ring,
    output logic [1:0]  active_slot,
    output logic        snoozing,
    output logic [2:0]  snooze_left,
    output logic [3:0]  missed
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RING   = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;

    logic [10:0] slot_q [4];
    logic [1:0]  state, state_n;
    logic [1:0]  active_n;
    logic [2:0]  left_n;
    logic [4:0]  ring_cnt, ring_cnt_n;
    logic [4:0]  snz_cnt, snz_cnt_n;
    logic [3:0]  match, miss_set, missed_n;
    logic [1:0]  grant;

    // Per-slot match against the freshly rolled-over minute, plus lowest-index grant
    always_comb begin
        grant = 2'd0;
        for (int i = 0; i < 4; i++)
            match[i] = min_tick & slot_en[i] & (slot_q[i] == time_in);
        for (int i = 3; i >= 0; i--)
            if (match[i]) grant = 2'(i);
    end

    // Session next-state logic; the active slot is latched so rewriting its
    // alarm time mid-session has no effect on the running session
    always_comb begin
        state_n    = state;
        active_n   = active_slot;
        left_n     = snooze_left;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        miss_set   = 4'b0;
        case (state)
            S_IDLE: begin
                if (|match) begin
                    state_n         = S_RING;
                    active_n        = grant;
                    left_n          = 3'(MAX_SNOOZE);
                    ring_cnt_n      = 5'd0;
                    miss_set        = match;
                    miss_set[grant] = 1'b0;
                end
            end
            S_RING, S_SNOOZE: begin
                // any alarm arriving during a session is missed
                miss_set = match;
                if (end_ring || !slot_en[active_slot]) begin
                    state_n = S_IDLE;
                end else if (state == S_RING) begin
                    if (snooze && snooze_left != 3'd0) begin
                        state_n   = S_SNOOZE;
                        snz_cnt_n = 5'(SNOOZE_MIN);
                        left_n    = snooze_left - 3'd1;
                    end else if (min_tick) begin
                        if (ring_cnt == 5'(TIMEOUT_MIN - 1)) begin
                            state_n               = S_IDLE;
                            miss_set[active_slot] = 1'b1;
                        end else begin
                            ring_cnt_n = ring_cnt + 5'd1;
                        end
                    end
                end else if (min_tick) begin
                    if (snz_cnt == 5'd1) begin
                        state_n    = S_RING;
                        ring_cnt_n = 5'd0;
                        snz_cnt_n  = 5'd0;
                    end else begin
                        snz_cnt_n = snz_cnt - 5'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (state_n == S_IDLE) begin
            active_n   = 2'd0;
            left_n     = 3'd0;
            ring_cnt_n = 5'd0;
            snz_cnt_n  = 5'd0;
        end
        // set beats clear on the same bit
        missed_n = (clear_missed ? 4'b0 : missed) | miss_set;
    end

    // Slot registers, writable in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) slot_q[i] <= 11'd0;
        end else if (set_time) begin
            slot_q[slot_sel] <= time_set_in;
        end
    end

    // Session state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ring        <= 1'b0;
            snoozing    <= 1'b0;
            active_slot <= 2'd0;
            snooze_left <= 3'd0;
            ring_cnt    <= 5'd0;
            snz_cnt     <= 5'd0;
            missed      <= 4'b0;
        end else begin
            state       <= state_n;
            ring        <= (state_n == S_RING);
            snoozing    <= (state_n == S_SNOOZE);
            active_slot <= active_n;
            snooze_left <= left_n;
            ring_cnt    <= ring_cnt_n;
            snz_cnt     <= snz_cnt_n;
            missed      <= missed_n;
        end
    end

endmodule
